// File: rtl/mrv1_tw_sync_unit.sv
// Warp-control execution unit: WSPAWN, TMC, BAR and WID ops with multi-barrier
// warp synchronisation and a registered one-cycle completion/itag return.
module mrv1_tw_sync_unit #(
  parameter int NUM_TW_P       = 8,
  parameter int NUM_THREADS_P  = 4,
  parameter int NUM_BARRIERS_P = 8,
  parameter int ITAG_WIDTH_P   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        tw_ctl_req_i,
  output logic                        tw_ctl_rdy_o,
  input  logic [1:0]                  tw_ctl_opc_i,
  input  logic [$clog2(NUM_TW_P)-1:0] tw_ctl_wid_i,
  input  logic [31:0]                 tw_ctl_src0_i,
  input  logic [31:0]                 tw_ctl_src1_i,
  input  logic [ITAG_WIDTH_P-1:0]     tw_ctl_itag_i,
  output logic                        tw_ctl_done_o,
  output logic [ITAG_WIDTH_P-1:0]     tw_ctl_itag_o,
  output logic [31:0]                 tw_ctl_wb_data_o,
  output logic                        wspawn_vld_o,
  output logic [NUM_TW_P-1:0]         wspawn_wmask_o,
  output logic [31:0]                 wspawn_pc_o,
  output logic                        tmc_vld_o,
  output logic [$clog2(NUM_TW_P)-1:0] tmc_wid_o,
  output logic [NUM_THREADS_P-1:0]    tmc_tmask_o,
  output logic [NUM_TW_P-1:0]         bar_stall_o,
  output logic                        bar_release_vld_o,
  output logic [NUM_TW_P-1:0]         bar_release_mask_o,
  output logic                        bar_err_o
);

  localparam int wid_width_lp = $clog2(NUM_TW_P);
  localparam int bid_width_lp = $clog2(NUM_BARRIERS_P);

  localparam logic [1:0] OPC_WSPAWN = 2'd0;
  localparam logic [1:0] OPC_TMC    = 2'd1;
  localparam logic [1:0] OPC_BAR    = 2'd2;
  localparam logic [1:0] OPC_WID    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_RELEASE} state_e;

  state_e state_reg, state_next;
  logic   rst_done_reg;

  // Per-barrier bookkeeping
  logic [NUM_TW_P-1:0]     bar_mask_reg [NUM_BARRIERS_P];
  logic [wid_width_lp-1:0] bar_size_reg [NUM_BARRIERS_P];
  logic [NUM_BARRIERS_P-1:0] bar_vld_reg;

  // Registered outputs
  logic                     done_reg;
  logic [ITAG_WIDTH_P-1:0]  itag_reg;
  logic [31:0]              wb_data_reg;
  logic                     wspawn_vld_reg;
  logic [NUM_TW_P-1:0]      wspawn_wmask_reg;
  logic [31:0]              wspawn_pc_reg;
  logic                     tmc_vld_reg;
  logic [wid_width_lp-1:0]  tmc_wid_reg;
  logic [NUM_THREADS_P-1:0] tmc_tmask_reg;
  logic [NUM_TW_P-1:0]      stall_reg, stall_next;
  logic                     release_vld_reg;
  logic [NUM_TW_P-1:0]      release_mask_reg;
  logic                     err_reg;

  logic                    accept;
  logic                    op_wspawn, op_tmc, op_bar, op_wid;
  logic [NUM_TW_P-1:0]     wid_onehot;
  logic [bid_width_lp-1:0] bar_bid;
  logic [wid_width_lp-1:0] bar_size_in;
  logic [wid_width_lp-1:0] bar_eff_size;
  logic [NUM_TW_P-1:0]     bar_cur_mask;
  logic                    bar_cur_vld;
  logic [NUM_TW_P-1:0]     bar_new_mask;
  logic [wid_width_lp:0]   bar_cnt;
  logic [wid_width_lp:0]   bar_target;
  logic                    bar_dup, bar_size_mismatch, bar_complete;
  logic                    err_event;
  logic [31:0]             spawn_cnt;
  logic [NUM_TW_P-1:0]     spawn_wmask;

  assign tw_ctl_rdy_o = rst_done_reg && (state_reg != ST_RELEASE);
  assign accept       = tw_ctl_req_i && tw_ctl_rdy_o;
  assign op_wspawn    = accept && (tw_ctl_opc_i == OPC_WSPAWN);
  assign op_tmc       = accept && (tw_ctl_opc_i == OPC_TMC);
  assign op_bar       = accept && (tw_ctl_opc_i == OPC_BAR);
  assign op_wid       = accept && (tw_ctl_opc_i == OPC_WID);
  assign wid_onehot   = {{(NUM_TW_P-1){1'b0}}, 1'b1} << tw_ctl_wid_i;

  assign bar_bid      = tw_ctl_src0_i[bid_width_lp-1:0];
  assign bar_size_in  = tw_ctl_src1_i[wid_width_lp-1:0];
  assign bar_cur_mask = bar_mask_reg[bar_bid];
  assign bar_cur_vld  = bar_vld_reg[bar_bid];
  // The first arrival defines the barrier size; later arrivals cannot change it.
  assign bar_eff_size = bar_cur_vld ? bar_size_reg[bar_bid] : bar_size_in;
  assign bar_new_mask = bar_cur_mask | wid_onehot;
  assign bar_dup           = bar_cur_vld && |(bar_cur_mask & wid_onehot);
  assign bar_size_mismatch = bar_cur_vld && (bar_size_in != bar_size_reg[bar_bid]);
  assign bar_target   = {1'b0, bar_eff_size} + (wid_width_lp+1)'(1);
  assign bar_complete = op_bar && (bar_cnt == bar_target);
  assign err_event    = (accept && stall_reg[tw_ctl_wid_i]) ||
                        (op_bar && (bar_dup || bar_size_mismatch));

  always_comb begin
    bar_cnt = '0;
    for (int i = 0; i < NUM_TW_P; i++) begin
      bar_cnt = bar_cnt + (wid_width_lp+1)'(bar_new_mask[i]);
    end
  end

  // Set before clear, so a size-1 barrier never raises the stall bit.
  always_comb begin
    stall_next = stall_reg;
    if (op_bar)       stall_next = stall_next | wid_onehot;
    if (bar_complete) stall_next = stall_next & ~bar_new_mask;
  end

  always_comb begin
    if (tw_ctl_src0_i == 32'd0)                  spawn_cnt = 32'd1;
    else if (tw_ctl_src0_i > 32'(NUM_TW_P))      spawn_cnt = 32'(NUM_TW_P);
    else                                         spawn_cnt = tw_ctl_src0_i;
  end

  // Warp 0 is the spawner and is never restarted.
  for (genvar gi = 0; gi < NUM_TW_P; gi++) begin : g_spawn
    if (gi == 0) begin : g_w0
      assign spawn_wmask[gi] = 1'b0;
    end else begin : g_wn
      assign spawn_wmask[gi] = 32'(gi) < spawn_cnt;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RELEASE: state_next = ST_IDLE;
      default: begin
        if (!accept)           state_next = ST_IDLE;
        else if (bar_complete) state_next = ST_RELEASE;
        else                   state_next = ST_RESP;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      rst_done_reg <= 1'b0;
      bar_vld_reg  <= '0;
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
        bar_mask_reg[b] <= '0;
        bar_size_reg[b] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
      if (op_bar) begin
        if (bar_complete) begin
          bar_vld_reg[bar_bid]  <= 1'b0;
          bar_mask_reg[bar_bid] <= '0;
        end else begin
          bar_mask_reg[bar_bid] <= bar_new_mask;
          if (!bar_cur_vld) begin
            bar_vld_reg[bar_bid]  <= 1'b1;
            bar_size_reg[bar_bid] <= bar_size_in;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_reg         <= 1'b0;
      itag_reg         <= '0;
      wb_data_reg      <= '0;
      wspawn_vld_reg   <= 1'b0;
      wspawn_wmask_reg <= '0;
      wspawn_pc_reg    <= '0;
      tmc_vld_reg      <= 1'b0;
      tmc_wid_reg      <= '0;
      tmc_tmask_reg    <= '0;
      stall_reg        <= '0;
      release_vld_reg  <= 1'b0;
      release_mask_reg <= '0;
      err_reg          <= 1'b0;
    end else begin
      done_reg        <= accept;
      wspawn_vld_reg  <= op_wspawn;
      tmc_vld_reg     <= op_tmc;
      release_vld_reg <= bar_complete;
      wb_data_reg     <= op_wid ? 32'(tw_ctl_wid_i) : 32'd0;
      stall_reg       <= stall_next;
      if (accept) itag_reg <= tw_ctl_itag_i;
      if (op_wspawn) begin
        wspawn_wmask_reg <= spawn_wmask;
        wspawn_pc_reg    <= tw_ctl_src1_i;
      end
      if (op_tmc) begin
        tmc_wid_reg   <= tw_ctl_wid_i;
        tmc_tmask_reg <= tw_ctl_src0_i[NUM_THREADS_P-1:0];
      end
      if (bar_complete) release_mask_reg <= bar_new_mask;
      if (err_event)    err_reg <= 1'b1;
    end
  end

  assign tw_ctl_done_o      = done_reg;
  assign tw_ctl_itag_o      = itag_reg;
  assign tw_ctl_wb_data_o   = wb_data_reg;
  assign wspawn_vld_o       = wspawn_vld_reg;
  assign wspawn_wmask_o     = wspawn_wmask_reg;
  assign wspawn_pc_o        = wspawn_pc_reg;
  assign tmc_vld_o          = tmc_vld_reg;
  assign tmc_wid_o          = tmc_wid_reg;
  assign tmc_tmask_o        = tmc_tmask_reg;
  assign bar_stall_o        = stall_reg;
  assign bar_release_vld_o  = release_vld_reg;
  assign bar_release_mask_o = release_mask_reg;
  assign bar_err_o          = err_reg;

endmodule

// File: tb/tb_mrv1_tw_sync_unit.sv
// Directed bench for mrv1_tw_sync_unit: spawn, TMC/WID, multi-barrier release and error cases.
module tb_mrv1_tw_sync_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        rdy;
  logic [1:0]  opc;
  logic [2:0]  wid;
  logic [31:0] src0, src1;
  logic [3:0]  itag_in;
  logic        done;
  logic [3:0]  itag_out;
  logic [31:0] wb_data;
  logic        sp_vld;
  logic [7:0]  sp_mask;
  logic [31:0] sp_pc;
  logic        tmc_vld;
  logic [2:0]  tmc_wid;
  logic [3:0]  tmc_tmask;
  logic [7:0]  stall;
  logic        rel_vld;
  logic [7:0]  rel_mask;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mrv1_tw_sync_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tw_ctl_req_i(req), .tw_ctl_rdy_o(rdy), .tw_ctl_opc_i(opc), .tw_ctl_wid_i(wid),
    .tw_ctl_src0_i(src0), .tw_ctl_src1_i(src1), .tw_ctl_itag_i(itag_in),
    .tw_ctl_done_o(done), .tw_ctl_itag_o(itag_out), .tw_ctl_wb_data_o(wb_data),
    .wspawn_vld_o(sp_vld), .wspawn_wmask_o(sp_mask), .wspawn_pc_o(sp_pc),
    .tmc_vld_o(tmc_vld), .tmc_wid_o(tmc_wid), .tmc_tmask_o(tmc_tmask),
    .bar_stall_o(stall), .bar_release_vld_o(rel_vld), .bar_release_mask_o(rel_mask),
    .bar_err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Presents one op at a negedge; returns at the next negedge with N+1 outputs visible.
  task automatic drive(input logic [1:0] o, input logic [2:0] w, input logic [31:0] s0,
                       input logic [31:0] s1, input logic [3:0] t);
    req = 1'b1; opc = o; wid = w; src0 = s0; src1 = s1; itag_in = t;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; opc = '0; wid = '0; src0 = '0; src1 = '0; itag_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy", 32'(rdy), 32'd1);

    // WSPAWN 4 warps
    drive(2'd0, 3'd0, 32'd4, 32'h8000_0100, 4'd3);
    check("sp_vld", 32'(sp_vld), 32'd1);
    check("sp_mask", 32'(sp_mask), 32'h0E);
    check("sp_pc", sp_pc, 32'h8000_0100);
    check("sp_done", 32'(done), 32'd1);
    check("sp_itag", 32'(itag_out), 32'd3);
    tick();
    check("sp_vld_pulse", 32'(sp_vld), 32'd0);
    check("sp_done_pulse", 32'(done), 32'd0);

    // Barrier 2, three warps
    drive(2'd2, 3'd0, 32'd2, 32'd2, 4'd1);
    check("b2_stall0", 32'(stall), 32'h01);
    check("b2_norel0", 32'(rel_vld), 32'd0);
    drive(2'd2, 3'd3, 32'd2, 32'd2, 4'd2);
    check("b2_stall1", 32'(stall), 32'h09);
    drive(2'd2, 3'd5, 32'd2, 32'd2, 4'd3);
    check("b2_rel_vld", 32'(rel_vld), 32'd1);
    check("b2_rel_mask", 32'(rel_mask), 32'h29);
    check("b2_stall2", 32'(stall), 32'h00);
    check("b2_rdy", 32'(rdy), 32'd0);
    check("b2_done", 32'(done), 32'd1);
    tick();
    check("b2_rdy_back", 32'(rdy), 32'd1);
    check("b2_rel_pulse", 32'(rel_vld), 32'd0);

    // Interleaved barriers 1 and 4
    drive(2'd2, 3'd1, 32'd1, 32'd1, 4'd4);
    check("b1_stall", 32'(stall), 32'h02);
    drive(2'd2, 3'd4, 32'd4, 32'd2, 4'd5);
    check("b4_stall", 32'(stall), 32'h12);
    drive(2'd2, 3'd2, 32'd1, 32'd1, 4'd6);
    check("b1_rel_vld", 32'(rel_vld), 32'd1);
    check("b1_rel_mask", 32'(rel_mask), 32'h06);
    check("b1_stall_after", 32'(stall), 32'h10);
    tick();
    drive(2'd2, 3'd6, 32'd4, 32'd2, 4'd7);
    check("b4_norel", 32'(rel_vld), 32'd0);
    check("b4_stall2", 32'(stall), 32'h50);
    drive(2'd2, 3'd7, 32'd4, 32'd2, 4'd8);
    check("b4_rel_mask", 32'(rel_mask), 32'hD0);
    check("b4_stall3", 32'(stall), 32'h00);
    tick();

    // Size-1 barrier releases at once
    drive(2'd2, 3'd6, 32'd3, 32'd0, 4'd9);
    check("b3_rel_vld", 32'(rel_vld), 32'd1);
    check("b3_rel_mask", 32'(rel_mask), 32'h40);
    check("b3_stall", 32'(stall), 32'h00);
    check("b3_done", 32'(done), 32'd1);
    check("no_err_yet", 32'(err), 32'd0);
    tick();

    // Back-to-back TMC then WID
    drive(2'd1, 3'd2, 32'h0000_0005, 32'd0, 4'd7);
    check("tmc_vld", 32'(tmc_vld), 32'd1);
    check("tmc_wid", 32'(tmc_wid), 32'd2);
    check("tmc_tmask", 32'(tmc_tmask), 32'h5);
    check("tmc_done", 32'(done), 32'd1);
    drive(2'd3, 3'd7, 32'd0, 32'd0, 4'd8);
    check("wid_done", 32'(done), 32'd1);
    check("wid_itag", 32'(itag_out), 32'd8);
    check("wid_data", wb_data, 32'd7);
    check("wid_tmc_pulse", 32'(tmc_vld), 32'd0);
    drive(2'd0, 3'd0, 32'd0, 32'h100, 4'd1);
    check("sp0_vld", 32'(sp_vld), 32'd1);
    check("sp0_mask", 32'(sp_mask), 32'h00);
    check("sp0_wb", wb_data, 32'd0);
    drive(2'd0, 3'd0, 32'd100, 32'h200, 4'd2);
    check("sp100_mask", 32'(sp_mask), 32'hFE);
    tick();

    // Errors on barrier 0 (src0 upper bits ignored)
    drive(2'd2, 3'd3, 32'h0000_0100, 32'd2, 4'd1);
    check("b0_stall", 32'(stall), 32'h08);
    check("b0_err0", 32'(err), 32'd0);
    drive(2'd2, 3'd3, 32'h0000_0100, 32'd2, 4'd2);
    check("dup_err", 32'(err), 32'd1);
    check("dup_done", 32'(done), 32'd1);
    check("dup_stall", 32'(stall), 32'h08);
    drive(2'd2, 3'd4, 32'd0, 32'd5, 4'd3);
    check("mis_norel", 32'(rel_vld), 32'd0);
    check("mis_stall", 32'(stall), 32'h18);
    drive(2'd2, 3'd1, 32'd0, 32'd2, 4'd4);
    check("b0_rel_vld", 32'(rel_vld), 32'd1);
    check("b0_rel_mask", 32'(rel_mask), 32'h1A);
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // Reset mid-barrier
    drive(2'd2, 3'd0, 32'd5, 32'd1, 4'd5);
    check("b5_stall", 32'(stall), 32'h01);
    rst_n = 1'b0;
    tick();
    check("mid_rst_stall", 32'(stall), 32'h00);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rdy", 32'(rdy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_rdy_back", 32'(rdy), 32'd1);
    drive(2'd2, 3'd2, 32'd5, 32'd1, 4'd6);
    check("b5_cleared_norel", 32'(rel_vld), 32'd0);
    check("b5_cleared_stall", 32'(stall), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
